icache_sa: RTL and testbench
============================

# icache_sa

Parametrised set-associative instruction cache between the fetch stage and the memory controller port. Successor to the direct-mapped single-word I-cache:
- configurable sets and ways;
- multi-word lines filled by a sequential refill FSM;
- per-set LRU replacement;
- single-cycle flush for `fence.i`.

Hits return data combinationally in the request cycle. Misses stall the fetch stage until the line is installed.

## Interface
- `WAYS`, default 2: associativity; 1 or 2.
- `SETS`, default 64: sets per way; power of two, at least 2.
- `LINE_WORDS`, default 4: 32-bit words per line; power of two, at least 1.
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `flush`, in, 1: invalidate all lines (`fence.i`).
- `read`, in, 1: fetch request, level.
- `addr`, in, 32: fetch byte address, word-aligned.
- `ready`, out, 1: `data` valid for `addr` this cycle.
- `data`, out, 32: instruction word.
- `ram_busy`, in, 1: memory controller cannot accept a request.
- `ram_ready`, in, 1: one-cycle pulse; `ram_data` valid.
- `ram_data`, in, 32: returned word.
- `ram_read`, out, 1: read request.
- `ram_addr`, out, 32: read address; stable while a word is outstanding.

## Operation
- Address split:
  - offset = `addr[OFF-1:2]` with OFF = 2 + log2(`LINE_WORDS`);
  - index = next log2(`SETS`) bits;
  - tag = remaining upper bits.
- Hit: `read` high, `!reset`, and some way has valid and tag match at index.
  - `ready` = 1 and `data` = stored word, combinationally.
  - On the clock edge, the set's LRU bit points to the other way.
- No hit: `ready` = 0, `data` = 0. In IDLE, the FSM latches line base and index into a fill register and moves to REQ.
- FSM states:
  - IDLE.
  - REQ: `ram_read` = `!ram_busy`; `ram_addr` = base + 4·cnt. Moves to WAIT when `ram_read` is high.
  - WAIT: `ram_read` = 0. On `ram_ready`, write the word into the line buffer at cnt. If cnt = `LINE_WORDS`−1 go to COMMIT, else cnt+1 and go to REQ.
  - COMMIT: write the line, tag and valid into the victim way, set LRU away from the victim, go to IDLE.
- Victim selection: lowest-numbered invalid way; otherwise the way named by LRU. When `WAYS`=1 it is always way 0.
- `read` deasserted or `addr` changed mid-fill: the fill completes and the line is installed. `ready` follows the current `addr` only.
- `flush`: clears every valid bit on the next edge.
  - If asserted in REQ or WAIT, set a discard flag. The fill drains (no abandoned RAM transaction) but COMMIT writes nothing.
  - `flush` wins over a same-cycle COMMIT.
- Hit during fill: served normally. The fill's target set is not yet modified.

## Timing
- Reset values: valid all 0, LRU all 0, FSM IDLE, cnt 0, discard 0, `ram_read` 0, `ram_addr` 0, `ready` 0, `data` 0.
- Hit latency: 0 cycles (same cycle as `read`).
- Miss latency: 1 (IDLE→REQ) + `LINE_WORDS` × (1 + ram latency) + 1 (COMMIT) cycles. The hit is seen the cycle after COMMIT.
- At most one RAM word outstanding. `ram_ready` outside WAIT is ignored.
- Reset mid-fill returns to IDLE immediately. The controller must tolerate the abandoned request.

## Configuration
- `ICACHE_EARLY_RESTART_EN`:
  - Defined: in WAIT, when `ram_ready` carries the word whose address equals `addr` and `read` is high, `ready` = 1 and `data` = `ram_data` that cycle. This is a combinational bypass; the fill continues.
  - Undefined: `ready` only on a hit.

## Structure
- A shared package holds the 32-bit data and address widths, plus FSM state encodings `IC_IDLE`, `IC_REQ`, `IC_WAIT` and `IC_COMMIT`.
- Derived widths (OFF, index, tag) are local parameters computed from the block parameters.
- One sub-module, `icache_way`: one way's tag, valid and data arrays, with a combinational lookup and a synchronous line write and flush.

## Test plan
- Cold miss, `WAYS`=2, `SETS`=64, `LINE_WORDS`=4, ram latency 2, `read` at 0x100 → 4 `ram_read` pulses at 0x100/104/108/10C, then COMMIT. `ready` high at 0x100 on cycle 14; 0x104–0x10C then hit with 0 latency.
- Three conflicting lines 0x0000, 0x0400, 0x0800 (same index 0), then 0x0000 → third fill evicts 0x0000 (LRU), so re-reading 0x0000 misses. 0x0400 and 0x0800 hit.
- `flush` after installing 0x200 → next `read` 0x200 misses and refetches 4 words.
- `flush` during WAIT of a fill at 0x300 → fill drains all 4 words; 0x300 still misses afterward.
- `ram_busy` held high 5 cycles in REQ → `ram_read` = 0 throughout, `ram_addr` stable. Request issued the cycle `ram_busy` falls.
- With `ICACHE_EARLY_RESTART_EN`, miss at 0x108 → `ready` = 1 in the `ram_ready` cycle for word 2, while the fill continues to word 3. Without the macro → `ready` only after COMMIT.

Source files
------------

// File: rtl/icache_sa_pkg.sv
// icache_sa_pkg: shared widths and refill FSM state encodings for the set-associative I-cache
package icache_sa_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    typedef enum logic [1:0] {IC_IDLE, IC_REQ, IC_WAIT, IC_COMMIT} ic_state_t;
endpackage

// File: rtl/icache_way.sv
// icache_way: one way's valid/tag/line arrays with combinational lookup, line write and flush
module icache_way
    import icache_sa_pkg::*;
#(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = 6,
    parameter int TAG_W      = 22,
    parameter int WOFF_W     = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [IDX_W-1:0]             idx,
    input  logic [TAG_W-1:0]             tag,
    input  logic [WOFF_W-1:0]            woff,
    output logic                         hit,
    output logic [DATA_W-1:0]            word,
    input  logic                         we,
    input  logic [IDX_W-1:0]             widx,
    input  logic [TAG_W-1:0]             wtag,
    input  logic [LINE_WORDS*DATA_W-1:0] wline,
    output logic                         wvalid
);
    logic [SETS-1:0]              valid;
    logic [TAG_W-1:0]             tags  [SETS];
    logic [LINE_WORDS*DATA_W-1:0] lines [SETS];

    assign hit    = valid[idx] && tags[idx] == tag;
    assign word   = lines[idx][woff*DATA_W +: DATA_W];
    assign wvalid = valid[widx];

    // valid bits: flush clears every line and beats a same-cycle install
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            valid <= '0;
        else if (flush)
            valid <= '0;
        else if (we)
            valid[widx] <= 1'b1;
    end

    // tag and line storage carry no reset; valid gates their use
    always_ff @(posedge clock) begin
        if (we) begin
            tags[widx]  <= wtag;
            lines[widx] <= wline;
        end
    end
endmodule

// File: rtl/icache_sa.sv
// icache_sa: set-associative I-cache with LRU, sequential line refill and fence.i flush; optional ICACHE_EARLY_RESTART_EN bypass
module icache_sa
    import icache_sa_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              read,
    input  logic [ADDR_W-1:0] addr,
    output logic              ready,
    output logic [DATA_W-1:0] data,
    input  logic              ram_busy,
    input  logic              ram_ready,
    input  logic [DATA_W-1:0] ram_data,
    output logic              ram_read,
    output logic [ADDR_W-1:0] ram_addr
);
    localparam int OFF    = 2 + $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF - IDX_W;
    localparam int WOFF_W = LINE_WORDS > 1 ? $clog2(LINE_WORDS) : 1;

    ic_state_t                    state;
    logic [WOFF_W-1:0]            cnt;
    logic                         discard;
    logic [ADDR_W-1:0]            base;
    logic [LINE_WORDS*DATA_W-1:0] lbuf;
    logic [SETS-1:0]              lru;
    logic [WAYS-1:0]              hit;
    logic [WAYS-1:0]              wvalid;
    logic [WAYS-1:0]              we;
    logic [DATA_W-1:0]            word [WAYS];
    logic [IDX_W-1:0]             idx;
    logic [IDX_W-1:0]             fill_idx;
    logic [TAG_W-1:0]             tag;
    logic [TAG_W-1:0]             fill_tag;
    logic [WOFF_W-1:0]            woff;
    logic                         hit_any;
    logic                         hit_way;
    logic                         victim;
    logic                         commit_ok;
    logic                         bypass;

    assign idx       = addr[OFF +: IDX_W];
    assign tag       = addr[ADDR_W-1 -: TAG_W];
    assign woff      = WOFF_W'((addr >> 2) & ADDR_W'(LINE_WORDS - 1));
    assign fill_idx  = base[OFF +: IDX_W];
    assign fill_tag  = base[ADDR_W-1 -: TAG_W];
    assign hit_any   = read && |hit;
    assign hit_way   = WAYS > 1 && hit[WAYS-1];
    assign victim    = WAYS > 1 && wvalid[0] && (!wvalid[WAYS-1] || lru[fill_idx]);
    assign commit_ok = state == IC_COMMIT && !discard && !flush;
    assign ram_read  = state == IC_REQ && !ram_busy;
    assign ram_addr  = base + ADDR_W'({cnt, 2'b00});
`ifdef ICACHE_EARLY_RESTART_EN
    assign bypass    = state == IC_WAIT && ram_ready && read && addr == ram_addr;
`else
    assign bypass    = 1'b0;
`endif
    assign ready     = !reset && (hit_any || bypass);
    assign data      = ready ? (hit_any ? (hit_way ? word[WAYS-1] : word[0]) : ram_data) : '0;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign we[w] = commit_ok && (victim == (w != 0));
        icache_way #(
            .SETS(SETS), .LINE_WORDS(LINE_WORDS), .IDX_W(IDX_W), .TAG_W(TAG_W), .WOFF_W(WOFF_W)
        ) u_way (
            .clock(clock), .reset(reset), .flush(flush),
            .idx(idx), .tag(tag), .woff(woff), .hit(hit[w]), .word(word[w]),
            .we(we[w]), .widx(fill_idx), .wtag(fill_tag), .wline(lbuf), .wvalid(wvalid[w])
        );
    end

    // refill FSM: latch line on a miss, fetch one word at a time, then install
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IC_IDLE;
            cnt     <= '0;
            discard <= 1'b0;
            base    <= '0;
            lbuf    <= '0;
        end else begin
            case (state)
                IC_IDLE: if (read && !(|hit)) begin
                    base  <= addr & ~ADDR_W'(LINE_WORDS * 4 - 1);
                    state <= IC_REQ;
                end
                IC_REQ: begin
                    if (flush) discard <= 1'b1;
                    if (ram_read) state <= IC_WAIT;
                end
                IC_WAIT: begin
                    if (flush) discard <= 1'b1;
                    if (ram_ready) begin
                        lbuf[cnt*DATA_W +: DATA_W] <= ram_data;
                        cnt   <= cnt == WOFF_W'(LINE_WORDS - 1) ? '0 : cnt + WOFF_W'(1);
                        state <= cnt == WOFF_W'(LINE_WORDS - 1) ? IC_COMMIT : IC_REQ;
                    end
                end
                IC_COMMIT: begin
                    discard <= 1'b0;
                    state   <= IC_IDLE;
                end
                default: state <= IC_IDLE;
            endcase
        end
    end

    // LRU bit names the way to evict next; an install overrides a same-set hit
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            lru <= '0;
        else begin
            if (hit_any) lru[idx] <= !hit_way;
            if (commit_ok) lru[fill_idx] <= !victim;
        end
    end
endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: table vectors, directed corner sequences and random traffic against a line-level cache model
module tb_icache_sa;
    localparam int WAYS = 2;
    localparam int SETS = 64;
    localparam int LW   = 4;
    localparam int OFF  = 4;

    logic        clock = 0, reset = 1, flush = 0, read = 0, ram_busy = 0, ram_ready = 0;
    logic [31:0] addr = 0, ram_data = 0;
    logic        ready, ram_read;
    logic [31:0] data, ram_addr;
    int          nvec = 0, nfail = 0;

    always #5 clock = ~clock;

    icache_sa #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (
        .clock(clock), .reset(reset), .flush(flush), .read(read), .addr(addr),
        .ready(ready), .data(data), .ram_busy(ram_busy), .ram_ready(ram_ready),
        .ram_data(ram_data), .ram_read(ram_read), .ram_addr(ram_addr)
    );

    // model: per-set list of resident line bases, oldest first
    logic [31:0] cache [SETS][$];
    bit          pend, disc, outst;
    int          nreq, nrecv, cd, lat = 2, nrr;
    logic [31:0] fbase, oaddr;
    bit          o_rdy, o_rr;
    logic [31:0] o_data, o_ra;

    typedef struct {
        bit          rd;
        logic [31:0] a;
        bit          rdy;
        bit          rr;
        logic [31:0] ra;
        logic [31:0] d;
    } vec_t;
    vec_t tbl [18];

    function automatic vec_t mk(bit rd, logic [31:0] a, bit rdy, bit rr, logic [31:0] ra, logic [31:0] d);
        vec_t v;
        v.rd = rd; v.a = a; v.rdy = rdy; v.rr = rr; v.ra = ra; v.d = d;
        return v;
    endfunction

    function automatic logic [31:0] memw(logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic int sidx(logic [31:0] a);
        return int'((a >> OFF) % SETS);
    endfunction

    function automatic logic [31:0] lbase(logic [31:0] a);
        return a & ~32'(LW * 4 - 1);
    endfunction

    function automatic bit present(logic [31:0] a);
        int s = sidx(a);
        for (int i = 0; i < cache[s].size(); i++)
            if (cache[s][i] == lbase(a)) return 1;
        return 0;
    endfunction

    task automatic touch(logic [31:0] a);
        int s = sidx(a);
        for (int i = 0; i < cache[s].size(); i++)
            if (cache[s][i] == lbase(a)) begin
                cache[s].delete(i);
                cache[s].push_back(lbase(a));
                return;
            end
    endtask

    task automatic clear_cache();
        for (int s = 0; s < SETS; s++) cache[s].delete();
    endtask

    task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    // one clock: drive inputs after negedge, check against model, advance model at posedge
    task automatic cycle(bit rs, bit rd, logic [31:0] a, bit fl, bit bs, bit spur);
        bit          rin, hit, er, err, commit_now;
        logic [31:0] rdat, ed;
        int          s;
        rin  = 0;
        rdat = $urandom;
        if (outst) begin
            cd--;
            if (cd == 0) begin rin = 1; rdat = memw(oaddr); end
        end else if (spur && !pend) rin = 1;
        reset = rs; read = rd; addr = a; flush = fl; ram_busy = bs; ram_ready = rin; ram_data = rdat;
        #1;
        o_rdy = ready; o_data = data; o_rr = ram_read; o_ra = ram_addr;
        if (ram_read) nrr++;
        hit = rd && !rs && present(a);
        er  = hit;
        ed  = hit ? memw(a) : 32'h0;
`ifdef ICACHE_EARLY_RESTART_EN
        if (!er && rd && !rs && outst && rin && oaddr == a) begin er = 1; ed = rdat; end
`endif
        err = !rs && pend && !outst && nreq < LW && !bs;
        check("ready", ready, er);
        check("data", data, ed);
        check("ram_read", ram_read, err);
        if (!rs && pend && !outst && nreq < LW) check("ram_addr", ram_addr, fbase + 32'(4 * nreq));
        @(posedge clock);
        if (rs) begin
            clear_cache();
            pend = 0; outst = 0; disc = 0;
        end else begin
            commit_now = pend && nrecv == LW;
            if (pend && fl) disc = 1;
            if (rin && outst) begin outst = 0; nrecv++; end
            if (err) begin outst = 1; cd = lat; oaddr = fbase + 32'(4 * nreq); nreq++; end
            s = sidx(fbase);
            if (commit_now && !disc && !fl && cache[s].size() == WAYS) void'(cache[s].pop_front());
            if (hit) touch(a);
            if (commit_now) begin
                if (!disc && !fl) cache[s].push_back(fbase);
                pend = 0;
            end else if (!pend && rd && !hit) begin
                pend = 1; fbase = lbase(a); nreq = 0; nrecv = 0; disc = 0;
            end
            if (fl) clear_cache();
        end
        @(negedge clock);
    endtask

    task automatic fetch(logic [31:0] a, output int n);
        n = 0;
        o_rdy = 0;
        while (!o_rdy && n < 100) begin
            cycle(0, 1, a, 0, 0, 0);
            n++;
        end
        check("fetch_done", o_rdy, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && pend; k++) cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic probe(logic [31:0] a, bit exp, string nm);
        cycle(0, 1, a, 0, 0, 0);
        check(nm, o_rdy, exp);
    endtask

    initial begin
        int          n;
        logic [31:0] a;
        for (int k = 0; k < 15; k++)
            tbl[k] = mk(1, 32'h100, k == 14, k % 3 == 1 && k <= 10, 32'h100 + 32'(4 * ((k - 1) / 3)),
                        k == 14 ? memw(32'h100) : 32'h0);
`ifdef ICACHE_EARLY_RESTART_EN
        tbl[3].rdy = 1;
        tbl[3].d   = memw(32'h100);
`endif
        for (int k = 15; k < 18; k++)
            tbl[k] = mk(1, 32'h100 + 32'(4 * (k - 14)), 1, 0, 32'h0, memw(32'h100 + 32'(4 * (k - 14))));

        cycle(1, 0, 0, 0, 0, 0);
        check("rst_ram_addr", o_ra, 0);
        check("rst_data", o_data, 0);
        cycle(1, 1, 32'h100, 0, 0, 0);
        check("rst_ready", o_rdy, 0);

        for (int i = 0; i < 18; i++) begin
            cycle(0, tbl[i].rd, tbl[i].a, 0, 0, 0);
            check("tbl_ready", o_rdy, tbl[i].rdy);
            check("tbl_data", o_data, tbl[i].d);
            check("tbl_ram_read", o_rr, tbl[i].rr);
            if (tbl[i].rr) check("tbl_ram_addr", o_ra, tbl[i].ra);
        end
        drain();

        fetch(32'h0000, n);
        check("conf_miss_lat", n, 15);
        fetch(32'h0400, n);
        fetch(32'h0800, n);
        probe(32'h0400, 1, "conf_hit_400");
        probe(32'h0800, 1, "conf_hit_800");
        probe(32'h0000, 0, "conf_evicted_000");
        drain();

        fetch(32'h0200, n);
        probe(32'h0200, 1, "fl_hit_before");
        cycle(0, 0, 0, 1, 0, 0);
        nrr = 0;
        fetch(32'h0200, n);
        check("fl_refetch_lat", n, 15);
        check("fl_refetch_words", nrr, 4);
        drain();

        nrr = 0;
        cycle(0, 1, 32'h0300, 0, 0, 0);
        for (int k = 0; k < 10 && !outst; k++) cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        drain();
        check("fd_words", nrr, 4);
        probe(32'h0300, 0, "fd_still_miss");
        drain();

        cycle(0, 1, 32'h0500, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cycle(0, 0, 0, 0, 1, 0);
            check("busy_ram_read", o_rr, 0);
            check("busy_ram_addr", o_ra, 32'h0500);
        end
        cycle(0, 0, 0, 0, 0, 0);
        check("busy_issue", o_rr, 1);
        drain();

        cycle(0, 0, 0, 1, 0, 0);
        fetch(32'h0108, n);
`ifdef ICACHE_EARLY_RESTART_EN
        check("er_latency", n, 10);
`else
        check("er_latency", n, 15);
`endif
        drain();
        probe(32'h0108, 1, "er_installed");

        cycle(0, 1, 32'h0600, 0, 0, 0);
        for (int k = 0; k < 10 && !outst; k++) cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 1, 32'h0108, 0, 0, 0);
        check("rst_mid_ready", o_rdy, 0);
        check("rst_mid_ram_read", o_rr, 0);
        check("rst_mid_ram_addr", o_ra, 0);
        cycle(0, 0, 0, 0, 0, 0);
        probe(32'h0108, 0, "rst_mid_cleared");
        drain();

        for (int i = 0; i < 3000; i++) begin
            lat = $urandom_range(1, 3);
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 1)) << 4) | (32'($urandom_range(0, 3)) << 2);
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7, a, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
